// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/stop recovery, byte presented on a valid/ready holding register.
// Latency: m_valid rises SYNC_STAGES + (1+DATA_BITS)*CLKS_PER_BIT + (CLKS_PER_BIT-1)/2 + 1 cycles after the start edge.
// Backpressure: one-entry holding register; a byte completing while it is full and not drained is dropped (overrun pulse).
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   rx         serial line, idles high
//   m_data     received byte (stable while m_valid && !m_ready)
//   m_valid    m_data holds an unconsumed byte
//   m_ready    consumer accepts m_data when m_valid && m_ready at posedge clk
//   frame_err  one-cycle pulse: stop bit sampled low
//   overrun    one-cycle pulse: byte completed while holding register full and not drained
//   busy       receiver is inside a frame or waiting out a break
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int MSB_FIRST    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] C_HALF = CW'(HALF);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic                 w_rx_s;
  logic [BW-1:0]        w_idx;

  logic [2:0]           r_state;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_overrun;

  // Input synchronizer; flops reset high so reset never looks like a start bit.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_rx_s = rx;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_sync <= '1;
        end else begin
          r_sync <= (r_sync << 1) | SYNC_STAGES'(rx);
        end
      end
      assign w_rx_s = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  // Storage position of the current data bit.
  assign w_idx = (MSB_FIRST != 0) ? (B_LAST - r_bit) : r_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;

      // Drain; a delivery in the same cycle overrides this below.
      if (r_valid && m_ready) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            // This cycle is count 0 of the start bit.
            r_bit <= '0;
            if (CLKS_PER_BIT == 1) begin
              // Detection sample doubles as the start validation sample.
              r_state <= S_DATA;
              r_cnt   <= '0;
            end else begin
              r_state <= S_START;
              r_cnt   <= CW'(1);
            end
          end
        end

        S_START: begin
          // When HALF is 0 the detection cycle already validated the start.
          if (r_cnt == C_HALF && w_rx_s) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == C_LAST) begin
            r_state <= S_DATA;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_DATA: begin
          if (r_cnt == C_HALF) begin
            r_shift[w_idx] <= w_rx_s;
          end
          if (r_cnt == C_LAST) begin
            r_cnt <= '0;
            if (r_bit == B_LAST) begin
              r_state <= S_STOP;
            end else begin
              r_bit <= r_bit + BW'(1);
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_STOP: begin
          // Act at mid-stop and leave immediately, so a back-to-back start
          // edge is seen from IDLE.
          if (r_cnt == C_HALF) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              r_state <= S_IDLE;
              if (!r_valid || m_ready) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_BREAK: begin
          // Hold off until the line returns high: one frame_err per break.
          if (w_rx_s) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign m_data    = r_data;
  assign m_valid   = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: three instances (16x MSB-first, bit-clock MSB-first, 16x LSB-first).
// Stimulus serializes bytes onto rx; expected bytes and arrival cycles go into a scoreboard
// that a negedge monitor pops whenever a DUT presents a new byte.
module tb_uart_rx;

  typedef struct {
    int         inst;
    logic [7:0] d;
    int         c;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_i      [3];
  logic       m_ready_i [3];
  logic [7:0] m_data_o  [3];
  logic       m_valid_o [3];
  logic       frame_err_o [3];
  logic       overrun_o [3];
  logic       busy_o    [3];

  int   cyc = 0;
  int   vec = 0;
  int   errs = 0;
  int   fe_cnt [3] = '{0, 0, 0};
  int   ov_cnt [3] = '{0, 0, 0};
  int   exp_fe [3] = '{0, 0, 0};
  int   exp_ov [3] = '{0, 0, 0};
  logic pv [3] = '{1'b0, 1'b0, 1'b0};
  logic pr [3] = '{1'b0, 1'b0, 1'b0};
  logic [7:0] pd [3];
  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_rx #(
      .CLKS_PER_BIT((g == 1) ? 1 : 16),
      .DATA_BITS   (8),
      .MSB_FIRST   ((g == 2) ? 0 : 1),
      .SYNC_STAGES (2)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx       (rx_i[g]),
      .m_data   (m_data_o[g]),
      .m_valid  (m_valid_o[g]),
      .m_ready  (m_ready_i[g]),
      .frame_err(frame_err_o[g]),
      .overrun  (overrun_o[g]),
      .busy     (busy_o[g])
    );
  end

  task automatic chk(input string nm, input int inst, input int act, input int exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s inst%0d: got 'h%0h, expected 'h%0h (cycle %0d)", nm, inst, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: a new byte is presented when m_valid is high and the
  // previous cycle either had no byte or had it accepted.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (frame_err_o[i] === 1'b1) fe_cnt[i]++;
      if (overrun_o[i] === 1'b1) ov_cnt[i]++;
      if (m_valid_o[i] === 1'b1 && (!pv[i] || pr[i])) begin
        if (sb.size() == 0 || sb[0].inst != i) begin
          vec++;
          errs++;
          $display("FAIL unexpected_byte inst%0d: got 'h%0h at cycle %0d, expected none", i, m_data_o[i], cyc);
        end else begin
          e = sb.pop_front();
          chk("data", i, int'(m_data_o[i]), int'(e.d));
          chk("latency", i, cyc, e.c);
        end
      end else if (m_valid_o[i] === 1'b1 && pv[i] && !pr[i]) begin
        chk("hold_stable", i, int'(m_data_o[i]), int'(pd[i]));
      end
      pv[i] = (m_valid_o[i] === 1'b1);
      pr[i] = (m_ready_i[i] === 1'b1);
      pd[i] = m_data_o[i];
    end
  end

  task automatic drive_bit(input int i, input logic b, input int n);
    rx_i[i] = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int cpb_of(input int i);
    return (i == 1) ? 1 : 16;
  endfunction

  // Called #1 after a posedge. Expected arrival: start edge cycle + 2 sync
  // stages + start and data bits + half of the stop bit + 1.
  task automatic send(input int i, input logic [7:0] d, input logic stop, input bit deliver);
    int cpb;
    exp_t x;
    cpb = cpb_of(i);
    if (deliver) begin
      x.inst = i;
      x.d    = d;
      x.c    = cyc + 2 + 9 * cpb + (cpb - 1) / 2 + 1;
      sb.push_back(x);
    end
    drive_bit(i, 1'b0, cpb);
    for (int k = 0; k < 8; k++) drive_bit(i, (i == 2) ? d[k] : d[7-k], cpb);
    drive_bit(i, stop, cpb);
  endtask

  task automatic check_counts(input int i);
    @(negedge clk);
    chk("frame_err_count", i, fe_cnt[i], exp_fe[i]);
    chk("overrun_count", i, ov_cnt[i], exp_ov[i]);
    chk("pending_bytes", i, sb.size(), 0);
    chk("busy_idle", i, int'(busy_o[i]), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input int i);
    chk("rst_m_valid", i, int'(m_valid_o[i]), 0);
    chk("rst_m_data", i, int'(m_data_o[i]), 0);
    chk("rst_busy", i, int'(busy_o[i]), 0);
    chk("rst_frame_err", i, int'(frame_err_o[i]), 0);
    chk("rst_overrun", i, int'(overrun_o[i]), 0);
  endtask

  // Abandon a frame mid-data with a one-cycle reset, then send a clean frame.
  task automatic rst_test(input int i);
    logic [7:0] d;
    int cpb;
    d   = 8'hC3;
    cpb = cpb_of(i);
    drive_bit(i, 1'b0, cpb);
    for (int k = 0; k < 3; k++) drive_bit(i, (i == 2) ? d[k] : d[7-k], cpb);
    drive_bit(i, (i == 2) ? d[3] : d[4], cpb / 2);
    chk("busy_mid_frame", i, int'(busy_o[i]), 1);
    rst = 1'b1;
    rx_i[i] = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs(i);
    @(posedge clk);
    #1;
    drive_bit(i, 1'b1, 20);
    send(i, 8'h5A, 1'b1, 1'b1);
    drive_bit(i, 1'b1, 20);
    check_counts(i);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rx_i[i]      = 1'b1;
      m_ready_i[i] = 1'b1;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) check_reset_outputs(i);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_bit(0, 1'b1, 5);

    // Bit-clock instance, single frame.
    send(1, 8'hA5, 1'b1, 1'b1);
    drive_bit(1, 1'b1, 10);
    check_counts(1);

    // Back-to-back frames, no idle gap.
    send(0, 8'h00, 1'b1, 1'b1);
    send(0, 8'hFF, 1'b1, 1'b1);
    send(0, 8'h3C, 1'b1, 1'b1);
    drive_bit(0, 1'b1, 40);
    check_counts(0);

    // Short low glitch: false start.
    drive_bit(0, 1'b0, 4);
    chk("busy_glitch", 0, int'(busy_o[0]), 1);
    drive_bit(0, 1'b1, 40);
    check_counts(0);

    // Stop bit low followed by a long break, then a good frame.
    send(0, 8'h81, 1'b0, 1'b0);
    exp_fe[0]++;
    drive_bit(0, 1'b0, 100);
    drive_bit(0, 1'b1, 20);
    send(0, 8'h42, 1'b1, 1'b1);
    drive_bit(0, 1'b1, 20);
    check_counts(0);

    // Overrun: holding register full and not drained.
    m_ready_i[0] = 1'b0;
    send(0, 8'h11, 1'b1, 1'b1);
    send(0, 8'h22, 1'b1, 1'b0);
    exp_ov[0]++;
    drive_bit(0, 1'b1, 20);
    @(negedge clk);
    chk("ovr_hold_data", 0, int'(m_data_o[0]), 'h11);
    chk("ovr_hold_valid", 0, int'(m_valid_o[0]), 1);
    @(posedge clk);
    #1;
    m_ready_i[0] = 1'b1;
    @(posedge clk);
    #1;
    m_ready_i[0] = 1'b0;
    @(negedge clk);
    chk("drain_valid", 0, int'(m_valid_o[0]), 0);
    chk("drain_data_kept", 0, int'(m_data_o[0]), 'h11);
    @(posedge clk);
    #1;
    check_counts(0);

    // Drain and load in the same cycle: no overrun.
    send(0, 8'h11, 1'b1, 1'b1);
    fork
      send(0, 8'h22, 1'b1, 1'b1);
      begin
        repeat (153) @(posedge clk);
        #1;
        m_ready_i[0] = 1'b1;
      end
    join
    drive_bit(0, 1'b1, 20);
    check_counts(0);

    // Randomized frames with random gaps (including none) on every instance.
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 25; n++) begin
        logic [7:0] d;
        int gap;
        d   = 8'($urandom);
        gap = int'($urandom_range(0, 3));
        send(i, d, 1'b1, 1'b1);
        if (gap != 0) drive_bit(i, 1'b1, gap * cpb_of(i) + int'($urandom_range(0, 5)));
      end
      drive_bit(i, 1'b1, 20);
      check_counts(i);
    end

    // Mid-frame reset, MSB-first and LSB-first.
    rst_test(0);
    rst_test(2);

    chk("scoreboard_empty", 0, sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
